// File: rtl/seg_scan_ctrl.sv
// 4-digit common-anode 7-segment scan controller with a double-buffered display value.
// A slot is REFRESH_DIV cycles: BLANK_CYCLES dark, then the selected digit lit.
module seg_scan_ctrl #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        lz_en,
  input  logic        load,
  input  logic [15:0] value,
  output logic [3:0]  nibble,
  output logic [3:0]  an,
  output logic        pending,
  output logic        frame_tick
);
  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  typedef enum logic {S_BLANK, S_ON} state_t;

  state_t        r_state, w_state_n;
  logic [CW-1:0] r_cnt, w_cnt_n;
  logic [1:0]    r_idx, w_idx_n;
  logic [15:0]   r_disp, r_shadow, w_disp_n;
  logic          w_slot_end, w_wrap, w_apply;
  logic [3:0]    w_supp, w_an_n;

  assign w_slot_end = (r_cnt == CW'(REFRESH_DIV - 1));
  assign w_wrap     = w_slot_end && (r_idx == 2'd3);
  // Shadow is committed at a frame wrap, or immediately while the scan is held off.
  assign w_apply    = r_pending_q() && (!enable || w_wrap);
  assign w_disp_n   = w_apply ? r_shadow : r_disp;

  function automatic logic r_pending_q();
    return pending;
  endfunction

  always_comb begin
    w_cnt_n = '0;
    w_idx_n = '0;
    if (enable) begin
      w_cnt_n = w_slot_end ? '0 : r_cnt + 1'b1;
      w_idx_n = w_slot_end ? r_idx + 2'd1 : r_idx;
    end
  end

  always_comb begin
    w_state_n = r_state;
    if (!enable) begin
      w_state_n = S_BLANK;
    end else begin
      case (r_state)
        S_BLANK: if (32'(w_cnt_n) >= BLANK_CYCLES) w_state_n = S_ON;
        S_ON:    if (w_slot_end && BLANK_CYCLES > 0) w_state_n = S_BLANK;
        default: w_state_n = S_BLANK;
      endcase
    end
  end

  // Digit i (i>0) is blanked when it and everything above it is zero.
  always_comb begin
    w_supp = '0;
    for (int i = 1; i < 4; i++)
      w_supp[i] = lz_en && ((w_disp_n >> (4 * i)) == 16'd0);
    w_an_n = 4'b1111;
    if (w_state_n == S_ON && !w_supp[w_idx_n])
      w_an_n[w_idx_n] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_BLANK;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_disp     <= '0;
      r_shadow   <= '0;
      pending    <= 1'b0;
      nibble     <= '0;
      an         <= 4'b1111;
      frame_tick <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_cnt      <= w_cnt_n;
      r_idx      <= w_idx_n;
      r_disp     <= w_disp_n;
      nibble     <= w_disp_n[4*w_idx_n +: 4];
      an         <= w_an_n;
      frame_tick <= enable && w_wrap;
      if (load) begin
        r_shadow <= value;
        pending  <= 1'b1;
      end else if (w_apply) begin
        pending  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: vector table, directed corner sequences, and random traffic
// against a frame-position model (pos = idx*RD + cnt).
module tb_seg_scan_ctrl;
  localparam int RD = 8;
  localparam int BL = 2;
  localparam int FR = 4 * RD;

  logic clk, reset, enable, lz_en, load;
  logic [15:0] value;
  logic [3:0] nibble, an;
  logic pending, frame_tick;

  seg_scan_ctrl #(.REFRESH_DIV(RD), .BLANK_CYCLES(BL)) dut (
    .clk(clk), .reset(reset), .enable(enable), .lz_en(lz_en), .load(load),
    .value(value), .nibble(nibble), .an(an), .pending(pending), .frame_tick(frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic rst, en, ld;
    logic [15:0] v;
    logic [3:0] e_an, e_nib;
    logic e_pend, e_ft;
  } vec_t;

  int n_chk = 0, n_pass = 0;
  int m_pos = 0;
  logic [15:0] m_disp = 0, m_shadow = 0;
  logic m_pend = 0, m_ft = 0, m_lz = 0, g_lz = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic logic [3:0] exp_an();
    int d = m_pos / RD, c = m_pos % RD;
    if (c < BL) return 4'hF;
    if (m_lz && d > 0 && (m_disp >> (4 * d)) == 16'd0) return 4'hF;
    return ~(4'b0001 << d);
  endfunction

  function automatic logic [3:0] exp_nib();
    int d = m_pos / RD;
    return 4'((m_disp >> (4 * d)) & 16'hF);
  endfunction

  task automatic model(input logic rst, en, ld, lz, input logic [15:0] v);
    logic wrap;
    m_lz = lz;
    if (rst) begin
      m_pos = 0; m_disp = 0; m_shadow = 0; m_pend = 0; m_ft = 0;
    end else if (!en) begin
      m_pos = 0; m_ft = 0;
      if (m_pend) begin m_disp = m_shadow; m_pend = 0; end
      if (ld) begin m_shadow = v; m_pend = 1; end
    end else begin
      wrap = (m_pos == FR - 1);
      m_pos = (m_pos + 1) % FR;
      m_ft = wrap;
      if (wrap && m_pend) begin m_disp = m_shadow; m_pend = 0; end
      if (ld) begin m_shadow = v; m_pend = 1; end
    end
  endtask

  task automatic step(input logic rst, en, ld, lz, input logic [15:0] v);
    @(negedge clk);
    reset = rst; enable = en; load = ld; lz_en = lz; value = v;
    @(posedge clk);
    model(rst, en, ld, lz, v);
    #1;
  endtask

  task automatic chk_model();
    chk("an", {12'd0, an}, {12'd0, exp_an()});
    chk("nibble", {12'd0, nibble}, {12'd0, exp_nib()});
    chk("pending", {15'd0, pending}, {15'd0, m_pend});
    chk("frame_tick", {15'd0, frame_tick}, {15'd0, m_ft});
  endtask

  task automatic stepc(input logic rst, en, ld, input logic [15:0] v);
    step(rst, en, ld, g_lz, v);
    chk_model();
  endtask

  task automatic run_to(input int target);
    int k = 0;
    while (m_pos != target && k < 2 * FR) begin
      stepc(0, 1, 0, 16'h0);
      k++;
    end
    if (m_pos != target) begin
      n_chk++;
      $display("FAIL run_to: pos %0d want %0d", m_pos, target);
    end
  endtask

  vec_t tv[$];
  int ft_cnt, on3, nib3_ok;

  initial begin
    reset = 1; enable = 0; load = 0; lz_en = 0; value = 0;
    // Reset then free run from digit 0 with nothing loaded.
    for (int i = 0; i < 3; i++) tv.push_back('{1, 0, 0, 16'h0, 4'hF, 4'h0, 0, 0});
    tv.push_back('{0, 1, 0, 16'h0, 4'hF, 4'h0, 0, 0});
    for (int i = 0; i < 6; i++) tv.push_back('{0, 1, 0, 16'h0, 4'hE, 4'h0, 0, 0});
    for (int i = 0; i < 2; i++) tv.push_back('{0, 1, 0, 16'h0, 4'hF, 4'h0, 0, 0});
    for (int i = 0; i < 6; i++) tv.push_back('{0, 1, 0, 16'h0, 4'hD, 4'h0, 0, 0});
    foreach (tv[i]) begin
      step(tv[i].rst, tv[i].en, tv[i].ld, 0, tv[i].v);
      chk($sformatf("tv%0d_an", i), {12'd0, an}, {12'd0, tv[i].e_an});
      chk($sformatf("tv%0d_nib", i), {12'd0, nibble}, {12'd0, tv[i].e_nib});
      chk($sformatf("tv%0d_pend", i), {15'd0, pending}, {15'd0, tv[i].e_pend});
      chk($sformatf("tv%0d_ft", i), {15'd0, frame_tick}, {15'd0, tv[i].e_ft});
    end

    // Load mid-frame; applied only at the wrap.
    stepc(0, 1, 1, 16'h1234);
    chk("t2_pend_set", {15'd0, pending}, 16'd1);
    run_to(FR - 1);
    chk("t2_pend_hold", {15'd0, pending}, 16'd1);
    stepc(0, 1, 0, 16'h0);
    chk("t2_wrap_ft", {15'd0, frame_tick}, 16'd1);
    chk("t2_wrap_pend", {15'd0, pending}, 16'd0);
    chk("t2_wrap_nib", {12'd0, nibble}, 16'h4);
    ft_cnt = 0; on3 = 0; nib3_ok = 0;
    for (int i = 0; i < FR; i++) begin
      stepc(0, 1, 0, 16'h0);
      if (frame_tick) ft_cnt++;
      if (an == 4'b0111) begin on3++; if (nibble == 4'h1) nib3_ok++; end
    end
    chk("t2_ft_per_frame", 16'(ft_cnt), 16'd1);
    chk("t2_dig3_on", 16'(on3), 16'd6);
    chk("t2_dig3_nib", 16'(nib3_ok), 16'd6);

    // Leading-zero suppression.
    g_lz = 1;
    stepc(0, 1, 1, 16'h0042);
    run_to(FR - 1);
    stepc(0, 1, 0, 16'h0);
    run_to(4);
    chk("t3_d0_an", {12'd0, an}, 16'hE);
    chk("t3_d0_nib", {12'd0, nibble}, 16'h2);
    run_to(RD + 4);
    chk("t3_d1_an", {12'd0, an}, 16'hD);
    chk("t3_d1_nib", {12'd0, nibble}, 16'h4);
    run_to(2 * RD + 4);
    chk("t3_d2_an", {12'd0, an}, 16'hF);
    run_to(3 * RD + 4);
    chk("t3_d3_an", {12'd0, an}, 16'hF);
    stepc(0, 1, 1, 16'h0000);
    run_to(FR - 1);
    stepc(0, 1, 0, 16'h0);
    run_to(4);
    chk("t3_zero_d0_an", {12'd0, an}, 16'hE);
    chk("t3_zero_d0_nib", {12'd0, nibble}, 16'h0);
    run_to(RD + 4);
    chk("t3_zero_d1_an", {12'd0, an}, 16'hF);
    g_lz = 0;

    // Load on the exact wrap cycle.
    stepc(0, 1, 1, 16'hAAAA);
    run_to(FR - 1);
    stepc(0, 1, 1, 16'hBBBB);
    chk("t4_pend_after_wrap", {15'd0, pending}, 16'd1);
    chk("t4_nib_A", {12'd0, nibble}, 16'hA);
    run_to(FR - 1);
    stepc(0, 1, 0, 16'h0);
    chk("t4_pend_clear", {15'd0, pending}, 16'd0);
    chk("t4_nib_B", {12'd0, nibble}, 16'hB);

    // Disable mid-slot with a pending value.
    stepc(0, 1, 1, 16'hC0DE);
    run_to(2 * RD + 3);
    stepc(0, 0, 0, 16'h0);
    chk("t5_off_an", {12'd0, an}, 16'hF);
    chk("t5_off_pend", {15'd0, pending}, 16'd0);
    stepc(0, 1, 0, 16'h0);
    chk("t5_blank1", {12'd0, an}, 16'hF);
    stepc(0, 1, 0, 16'h0);
    chk("t5_on_an", {12'd0, an}, 16'hE);
    chk("t5_on_nib", {12'd0, nibble}, 16'hE);

    // Reset mid-slot with a pending value.
    stepc(0, 1, 1, 16'h1111);
    run_to(3 * RD + 4);
    stepc(1, 1, 1, 16'h5555);
    chk("t6_an", {12'd0, an}, 16'hF);
    chk("t6_nib", {12'd0, nibble}, 16'h0);
    chk("t6_pend", {15'd0, pending}, 16'd0);
    chk("t6_ft", {15'd0, frame_tick}, 16'd0);
    stepc(0, 1, 0, 16'h0);
    stepc(0, 1, 0, 16'h0);
    chk("t6_restart_d0", {12'd0, an}, 16'hE);

    // Random traffic against the model.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(31) == 0) g_lz = ~g_lz;
      stepc($urandom_range(99) == 0, $urandom_range(15) != 0, $urandom_range(7) == 0,
            $urandom_range(1) ? 16'($urandom) : 16'($urandom_range(255)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
